// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_arbiter
// Brief    : Shares one SRAM-like memory port between the instruction-fetch
//            and load/store requesters. Data has priority; an anti-starvation
//            counter forces an inst grant after STARVE_LIMIT data wins.
//            Define SRAM_BUS_ARBITER_PERF_EN to add grant/wait perf counters.
// Revision : 1.0  initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef SRAM_BUS_ARBITER_PERF_EN
    output logic [31:0] perf_inst_grants,
    output logic [31:0] perf_data_grants,
    output logic [31:0] perf_wait_cycles,
`endif
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ADDR  = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic        r_owner;        // 0 = inst, 1 = data
    logic [3:0]  r_starve_cnt;
    logic        r_mem_req;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_idle;
    logic        w_grant_data;
    logic        w_grant_inst;
    logic        w_resp;
    logic        w_busy;

    assign w_idle       = (r_state == c_IDLE);
    assign w_grant_data = w_idle && data_req && (!inst_req || (r_starve_cnt < c_LIMIT));
    assign w_grant_inst = w_idle && inst_req && !w_grant_data;
    // A response is accepted in DATA, or in ADDR when memory accepts and completes together.
    assign w_resp       = mem_data_ok && ((r_state == c_DATA) || ((r_state == c_ADDR) && mem_addr_ok));
    assign w_busy       = !w_idle;

    assign inst_addr_ok = w_grant_inst;
    assign data_addr_ok = w_grant_data;
    assign inst_data_ok = w_resp && !r_owner;
    assign data_data_ok = w_resp && r_owner;
    assign inst_rdata   = (w_busy && !r_owner) ? mem_rdata : 32'h0;
    assign data_rdata   = (w_busy && r_owner)  ? mem_rdata : 32'h0;

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_wr;
    assign mem_size  = r_size;
    assign mem_wstrb = r_wstrb;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_mem_req    <= 1'b0;
            r_wr         <= 1'b0;
            r_size       <= 2'd0;
            r_wstrb      <= 4'd0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!inst_req || w_grant_inst) begin
                        r_starve_cnt <= 4'd0;
                    end else if (w_grant_data && (r_starve_cnt < c_LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                    if (w_grant_inst || w_grant_data) begin
                        r_owner   <= w_grant_data;
                        r_wr      <= w_grant_data ? data_wr    : inst_wr;
                        r_size    <= w_grant_data ? data_size  : inst_size;
                        r_wstrb   <= w_grant_data ? data_wstrb : inst_wstrb;
                        r_addr    <= w_grant_data ? data_addr  : inst_addr;
                        r_wdata   <= w_grant_data ? data_wdata : inst_wdata;
                        r_mem_req <= 1'b1;
                        r_state   <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= mem_data_ok ? c_IDLE : c_DATA;
                    end
                end
                c_DATA: begin
                    if (mem_data_ok) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_BUS_ARBITER_PERF_EN
    logic        w_wait;
    logic [31:0] r_perf_inst;
    logic [31:0] r_perf_data;
    logic [31:0] r_perf_wait;

    assign w_wait = (inst_req && !w_grant_inst) || (data_req && !w_grant_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_inst <= 32'h0;
            r_perf_data <= 32'h0;
            r_perf_wait <= 32'h0;
        end else begin
            if (w_grant_inst) r_perf_inst <= r_perf_inst + 32'd1;
            if (w_grant_data) r_perf_data <= r_perf_data + 32'd1;
            if (w_wait)       r_perf_wait <= r_perf_wait + 32'd1;
        end
    end

    assign perf_inst_grants = r_perf_inst;
    assign perf_data_grants = r_perf_data;
    assign perf_wait_cycles = r_perf_wait;
`endif

endmodule
`default_nettype wire
